pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Registered next-PC unit for the fetch stage. Holds the architectural PC and
//  resolves j/jal/jr/bne/blt/bex redirects (targets and compares computed here).
//  Buffers a redirect that arrives during a fetch stall and applies it when the stall lifts.
//  Issues a one-cycle flush pulse to squash younger instructions.
// PARAMETERS
//  ADDR_W     32         PC/register width; all PC arithmetic is modulo 2^ADDR_W
//  N_W        17         branch immediate width, signed
//  T_W        27         jump target field width, unsigned
//  RESET_PC   0          PC value loaded on reset
// PORTS
//  clock       in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  stall       in   1       1 = hold PC (fetch/decode stalled)
//  ctrl_j, ctrl_jal, ctrl_jr, ctrl_bne, ctrl_blt, ctrl_bex  in 1 each   decoded op of resolving instr
//  br_pc       in   ADDR_W  PC of the resolving branch/jump instruction
//  imm_n       in   N_W     branch offset N
//  target_t    in   T_W     jump target T
//  reg_a       in   ADDR_W  $rs operand (bne/blt)
//  reg_b       in   ADDR_W  $rd operand (bne/blt); jr target
//  rstatus     in   ADDR_W  $r30 value for bex
//  pc          out  ADDR_W  current fetch PC
//  pc_plus1    out  ADDR_W  pc + 1 (comb), return address for jal
//  flush       out  1       1-cycle pulse when a redirect is loaded into pc
//  redir_pend  out  1       a buffered redirect awaits stall release
// BEHAVIOUR
//  Reset (async, reset==0): pc=RESET_PC, flush=0, redir_pend=0, state=RUN, pend_tgt=0.
//  Redirect decode, comb, priority j|jal > jr > bex > bne > blt:
//   j/jal: tgt = zero-extend(target_t); always taken.
//   jr:    tgt = reg_b; always taken.
//   bex:   taken iff rstatus != 0; tgt = zero-extend(target_t).
//   bne:   taken iff reg_a != reg_b; tgt = br_pc + 1 + sext(imm_n).
//   blt:   taken iff signed(reg_b) < signed(reg_a); tgt = br_pc + 1 + sext(imm_n).
//   Not-taken branch or no ctrl asserted: no redirect (take=0).
//  States: RUN (no redirect pending), PEND (redirect buffered).
//   RUN,  stall=0, take=1: pc<=tgt; flush<=1 next cycle; stay RUN.
//   RUN,  stall=0, take=0: pc<=pc+1; flush<=0.
//   RUN,  stall=1, take=1: pc held; pend_tgt<=tgt; -> PEND.
//   RUN,  stall=1, take=0: pc held.
//   PEND, stall=1: pc held; take=1 overwrites pend_tgt (newest wins).
//   PEND, stall=0: pc<=(take ? tgt : pend_tgt); flush<=1; -> RUN.
//  flush is registered: high exactly the cycle after pc loads a redirect; never 2 cycles
//   back-to-back unless two redirects load on consecutive edges.
//  redir_pend = (state==PEND), registered.
//  Latency: redirect visible on pc 1 edge after take with stall=0.
//  Arithmetic: pc+1 and branch target wrap at 2^ADDR_W (all-ones + 1 -> 0).
//  If T_W >= ADDR_W, target_t truncated to ADDR_W LSBs.
//  Reset mid-PEND discards pend_tgt; pc returns to RESET_PC.
// CONFIGURATION
//  PC_RANGE_CHECK_EN defined: extra param IMEM_DEPTH (default 4096) and output
//   range_err (1b). A redirect whose tgt >= IMEM_DEPTH is not loaded: pc holds,
//   range_err pulses 1 cycle, flush stays 0, state -> RUN. range_err resets to 0.
//  Not defined: no range_err port; every target loaded unchecked.
// TESTING
//  Reset release, stall=0, no ctrl, 4 clocks -> pc = 0,1,2,3,4; flush=0.
//  ctrl_bne, br_pc=10, imm_n=-3, reg_a=5, reg_b=6 -> pc=8 next edge, flush=1 one cycle.
//  ctrl_blt, reg_b=-1, reg_a=2, N=4, br_pc=20 -> pc=25; reg_b=3 -> not taken, pc+1.
//  stall=1, ctrl_j T=0x40, then ctrl_jr reg_b=0x99 still stalled, stall=0 -> pc=0x99,
//   redir_pend 1 during stall, flush once.
//  pc=0xFFFFFFFF, stall=0 -> pc=0; ctrl_bex rstatus=0 -> no redirect; rstatus=1, T=7 -> pc=7.
//  PC_RANGE_CHECK_EN, IMEM_DEPTH=4096, ctrl_j T=5000 -> pc held, range_err=1, flush=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Registered next-PC unit: resolves j/jal/jr/bex/bne/blt redirects, buffers one across a stall.
// Optional `PC_RANGE_CHECK_EN` rejects redirect targets at or beyond IMEM_DEPTH.
module pc_sequencer #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       N_W      = 17,
    parameter int unsigned       T_W      = 27,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef PC_RANGE_CHECK_EN
    ,
    parameter int unsigned       IMEM_DEPTH = 4096
`endif
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_ctrl_j,
    input  logic              i_ctrl_jal,
    input  logic              i_ctrl_jr,
    input  logic              i_ctrl_bne,
    input  logic              i_ctrl_blt,
    input  logic              i_ctrl_bex,
    input  logic [ADDR_W-1:0] i_br_pc,
    input  logic [N_W-1:0]    i_imm_n,
    input  logic [T_W-1:0]    i_target_t,
    input  logic [ADDR_W-1:0] i_reg_a,
    input  logic [ADDR_W-1:0] i_reg_b,
    input  logic [ADDR_W-1:0] i_rstatus,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus1,
    output logic              o_flush,
`ifdef PC_RANGE_CHECK_EN
    output logic              o_range_err,
`endif
    output logic              o_redir_pend
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pend_tgt;
    logic              r_flush;

    logic              w_take;
    logic [ADDR_W-1:0] w_tgt;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_branch_tgt;
    logic              w_load;
    logic [ADDR_W-1:0] w_load_tgt;
    logic              w_tgt_ok;

    // A cast of target_t zero-extends or truncates to ADDR_W as needed.
    assign w_jump_tgt   = ADDR_W'(i_target_t);
    assign w_branch_tgt = i_br_pc + ADDR_W'(1) + ADDR_W'($signed(i_imm_n));

    // Redirect decode; a selected-but-not-taken branch blocks lower-priority ops.
    always_comb begin
        w_take = 1'b0;
        w_tgt  = '0;
        if (i_ctrl_j || i_ctrl_jal) begin
            w_take = 1'b1;
            w_tgt  = w_jump_tgt;
        end else if (i_ctrl_jr) begin
            w_take = 1'b1;
            w_tgt  = i_reg_b;
        end else if (i_ctrl_bex) begin
            w_take = (i_rstatus != '0);
            w_tgt  = w_jump_tgt;
        end else if (i_ctrl_bne) begin
            w_take = (i_reg_a != i_reg_b);
            w_tgt  = w_branch_tgt;
        end else if (i_ctrl_blt) begin
            w_take = ($signed(i_reg_b) < $signed(i_reg_a));
            w_tgt  = w_branch_tgt;
        end
    end

    assign w_load     = w_take || (r_state == ST_PEND);
    assign w_load_tgt = w_take ? w_tgt : r_pend_tgt;

`ifdef PC_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] IMEM_LIM = (ADDR_W + 1)'(IMEM_DEPTH);
    logic r_range_err;
    assign w_tgt_ok    = ({1'b0, w_load_tgt} < IMEM_LIM);
    assign o_range_err = r_range_err;
`else
    assign w_tgt_ok = 1'b1;
`endif

    // PC / state update; flush and range_err are single-cycle pulses.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_pend_tgt <= '0;
            r_flush    <= 1'b0;
`ifdef PC_RANGE_CHECK_EN
            r_range_err <= 1'b0;
`endif
        end else begin
            r_flush <= 1'b0;
`ifdef PC_RANGE_CHECK_EN
            r_range_err <= 1'b0;
`endif
            if (!i_stall) begin
                r_state <= ST_RUN;
                if (!w_load) begin
                    r_pc <= r_pc + ADDR_W'(1);
                end else if (w_tgt_ok) begin
                    r_pc    <= w_load_tgt;
                    r_flush <= 1'b1;
                end else begin
`ifdef PC_RANGE_CHECK_EN
                    r_range_err <= 1'b1;
`endif
                end
            end else if (w_take) begin
                r_pend_tgt <= w_tgt;
                r_state    <= ST_PEND;
            end
        end
    end

    assign o_pc         = r_pc;
    assign o_pc_plus1   = r_pc + ADDR_W'(1);
    assign o_flush      = r_flush;
    assign o_redir_pend = (r_state == ST_PEND);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected pc/flush/pend pushed per driven cycle, popped after the edge.
// Range-check scenarios run only when PC_RANGE_CHECK_EN is defined.
module tb_pc_sequencer;

    localparam logic [5:0] CJ   = 6'b100000;
    localparam logic [5:0] CJAL = 6'b010000;
    localparam logic [5:0] CJR  = 6'b001000;
    localparam logic [5:0] CBEX = 6'b000100;
    localparam logic [5:0] CBNE = 6'b000010;
    localparam logic [5:0] CBLT = 6'b000001;

    typedef struct {
        logic        stall;
        logic [5:0]  ctrl;
        logic [31:0] br_pc;
        logic [31:0] reg_a;
        logic [31:0] reg_b;
        logic [31:0] rstatus;
        logic [16:0] imm;
        logic [26:0] tgt;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_pend;
        logic        e_rerr;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc1;
        logic        flush;
        logic        pend;
        logic        rerr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        c_j, c_jal, c_jr, c_bne, c_blt, c_bex;
    logic [31:0] br_pc, reg_a, reg_b, rstatus;
    logic [16:0] imm_n;
    logic [26:0] target_t;
    logic [31:0] pc, pc_plus1;
    logic        flush, redir_pend;
    logic        range_err;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_stall     (stall),
        .i_ctrl_j    (c_j),
        .i_ctrl_jal  (c_jal),
        .i_ctrl_jr   (c_jr),
        .i_ctrl_bne  (c_bne),
        .i_ctrl_blt  (c_blt),
        .i_ctrl_bex  (c_bex),
        .i_br_pc     (br_pc),
        .i_imm_n     (imm_n),
        .i_target_t  (target_t),
        .i_reg_a     (reg_a),
        .i_reg_b     (reg_b),
        .i_rstatus   (rstatus),
        .o_pc        (pc),
        .o_pc_plus1  (pc_plus1),
        .o_flush     (flush),
`ifdef PC_RANGE_CHECK_EN
        .o_range_err (range_err),
`endif
        .o_redir_pend(redir_pend)
    );

`ifndef PC_RANGE_CHECK_EN
    assign range_err = 1'b0;
`endif

    function automatic stim_t mk(input logic s, input logic [5:0] c, input logic [31:0] bp,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] rs,
                                 input int im, input logic [26:0] t, input logic [31:0] epc,
                                 input logic ef, input logic ep, input logic er);
        stim_t r;
        r.stall = s;    r.ctrl = c;     r.br_pc = bp;  r.reg_a = a;   r.reg_b = b;
        r.rstatus = rs; r.imm = 17'(im); r.tgt = t;    r.e_pc = epc;  r.e_flush = ef;
        r.e_pend = ep;  r.e_rerr = er;
        return r;
    endfunction

    // Drives one row of stimulus and records what the next edge must produce.
    task automatic apply(input stim_t r);
        exp_t e;
        stall = r.stall;
        {c_j, c_jal, c_jr, c_bex, c_bne, c_blt} = r.ctrl;
        br_pc = r.br_pc; reg_a = r.reg_a; reg_b = r.reg_b; rstatus = r.rstatus;
        imm_n = r.imm;   target_t = r.tgt;
        e.pc = r.e_pc; e.pc1 = r.e_pc + 32'd1; e.flush = r.e_flush; e.pend = r.e_pend; e.rerr = r.e_rerr;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t rows[$];
        exp_t  e;
        rst_n = 1'b0;
        apply(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        void'(exp_q.pop_front());
        repeat (2) tick();
        n_checks++;
        if ({pc, flush, redir_pend} !== {32'h0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_hold: pc=%h flush=%b pend=%b expected pc=0 flush=0 pend=0", pc, flush, redir_pend);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (pc !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_release: pc=%h expected 0", pc);
        end
        for (int i = 1; i <= 4; i++) rows.push_back(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 32'(i), 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({pc, pc_plus1, flush, redir_pend} !== {e.pc, e.pc1, e.flush, e.pend}) begin
                n_errors++;
                $display("FAIL seq_inc[%0d]: pc=%h pc1=%h flush=%b pend=%b expected pc=%h pc1=%h flush=%b pend=%b",
                         i, pc, pc_plus1, flush, redir_pend, e.pc, e.pc1, e.flush, e.pend);
            end
        end
    endtask

    task automatic test_branches();
        stim_t rows[$];
        exp_t  e;
        rows.push_back(mk(0, CBNE, 10, 5, 6, 0, -3, 0, 32'd8, 1, 0, 0));
        rows.push_back(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 32'd9, 0, 0, 0));
        rows.push_back(mk(0, CBNE, 10, 7, 7, 0, -3, 0, 32'd10, 0, 0, 0));
        rows.push_back(mk(0, CBLT, 20, 2, 32'hFFFF_FFFF, 0, 4, 0, 32'd25, 1, 0, 0));
        rows.push_back(mk(0, CBLT, 20, 2, 3, 0, 4, 0, 32'd26, 0, 0, 0));
        rows.push_back(mk(0, CJAL, 0, 0, 0, 0, 0, 27'h20, 32'h20, 1, 0, 0));
        rows.push_back(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 32'h21, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({pc, pc_plus1, flush, redir_pend} !== {e.pc, e.pc1, e.flush, e.pend}) begin
                n_errors++;
                $display("FAIL branch[%0d]: pc=%h pc1=%h flush=%b pend=%b expected pc=%h pc1=%h flush=%b pend=%b",
                         i, pc, pc_plus1, flush, redir_pend, e.pc, e.pc1, e.flush, e.pend);
            end
        end
    endtask

    task automatic test_stall_pending();
        stim_t rows[$];
        exp_t  e;
        rows.push_back(mk(1, 6'b0, 0, 0, 0, 0, 0, 0, 32'h21, 0, 0, 0));
        rows.push_back(mk(1, CJ, 0, 0, 0, 0, 0, 27'h40, 32'h21, 0, 1, 0));
        rows.push_back(mk(1, CJR, 0, 0, 32'h99, 0, 0, 0, 32'h21, 0, 1, 0));
        rows.push_back(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 32'h99, 1, 0, 0));
        rows.push_back(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 32'h9A, 0, 0, 0));
        rows.push_back(mk(1, CJ, 0, 0, 0, 0, 0, 27'h30, 32'h9A, 0, 1, 0));
        rows.push_back(mk(0, CJR, 0, 0, 32'h55, 0, 0, 0, 32'h55, 1, 0, 0));
        rows.push_back(mk(0, CJ | CJR, 0, 0, 32'h77, 0, 0, 27'h10, 32'h10, 1, 0, 0));
        rows.push_back(mk(0, CJR | CBNE, 0, 1, 32'h60, 0, 0, 0, 32'h60, 1, 0, 0));
        rows.push_back(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 32'h61, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({pc, pc_plus1, flush, redir_pend} !== {e.pc, e.pc1, e.flush, e.pend}) begin
                n_errors++;
                $display("FAIL stall_pend[%0d]: pc=%h pc1=%h flush=%b pend=%b expected pc=%h pc1=%h flush=%b pend=%b",
                         i, pc, pc_plus1, flush, redir_pend, e.pc, e.pc1, e.flush, e.pend);
            end
        end
    endtask

    task automatic test_wrap_bex();
        stim_t rows[$];
        exp_t  e;
`ifndef PC_RANGE_CHECK_EN
        rows.push_back(mk(0, CJR, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0));
        rows.push_back(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
`endif
        rows.push_back(mk(0, CBNE, 32'hFFFF_FFFF, 1, 2, 0, 0, 0, 32'h0, 1, 0, 0));
        rows.push_back(mk(0, CBEX, 0, 0, 0, 0, 0, 27'h7, 32'h1, 0, 0, 0));
        rows.push_back(mk(0, CBEX, 0, 0, 0, 1, 0, 27'h7, 32'h7, 1, 0, 0));
        rows.push_back(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 32'h8, 0, 0, 0));
        rows.push_back(mk(1, CJ, 0, 0, 0, 0, 0, 27'h40, 32'h8, 0, 1, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({pc, pc_plus1, flush, redir_pend} !== {e.pc, e.pc1, e.flush, e.pend}) begin
                n_errors++;
                $display("FAIL wrap_bex[%0d]: pc=%h pc1=%h flush=%b pend=%b expected pc=%h pc1=%h flush=%b pend=%b",
                         i, pc, pc_plus1, flush, redir_pend, e.pc, e.pc1, e.flush, e.pend);
            end
        end
    endtask

    // Reset while a redirect is buffered must discard it.
    task automatic test_reset_mid_pend();
        exp_t e;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pc, flush, redir_pend} !== {32'h0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_mid_pend: pc=%h flush=%b pend=%b expected pc=0 flush=0 pend=0", pc, flush, redir_pend);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 32'h1, 0, 0, 0));
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if ({pc, flush, redir_pend} !== {e.pc, e.flush, e.pend}) begin
            n_errors++;
            $display("FAIL after_reset_pend: pc=%h flush=%b pend=%b expected pc=%h flush=%b pend=%b",
                     pc, flush, redir_pend, e.pc, e.flush, e.pend);
        end
    endtask

    task automatic test_range();
        stim_t rows[$];
        exp_t  e;
        rows.push_back(mk(0, CJ, 0, 0, 0, 0, 0, 27'd5000, 32'h1, 0, 0, 1));
        rows.push_back(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 32'h2, 0, 0, 0));
        rows.push_back(mk(1, CJ, 0, 0, 0, 0, 0, 27'd5000, 32'h2, 0, 1, 0));
        rows.push_back(mk(0, 6'b0, 0, 0, 0, 0, 0, 0, 32'h2, 0, 0, 1));
        rows.push_back(mk(0, CJ, 0, 0, 0, 0, 0, 27'd4095, 32'd4095, 1, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({pc, flush, redir_pend, range_err} !== {e.pc, e.flush, e.pend, e.rerr}) begin
                n_errors++;
                $display("FAIL range[%0d]: pc=%h flush=%b pend=%b rerr=%b expected pc=%h flush=%b pend=%b rerr=%b",
                         i, pc, flush, redir_pend, range_err, e.pc, e.flush, e.pend, e.rerr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branches();
        test_stall_pending();
        test_wrap_bex();
        test_reset_mid_pend();
`ifdef PC_RANGE_CHECK_EN
        test_range();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
